// File: rtl/i2c_codec_cfg.sv
// WM8731 setup sequencer: replays an 11-word register table as I2C write frames after reset or on start.
// Optional macro I2C_ACK_CHECK_EN: sample ACK slots, abort the table on NACK and raise ack_err.
module i2c_codec_cfg #(
    parameter int         CLK_DIV  = 25,
    parameter logic [7:0] DEV_ADDR = 8'h34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [3:0] cur_idx
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_FIN} state_t;

    state_t        r_state;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;
    logic [7:0]    r_sh;
    logic [3:0]    r_idx;
    logic [DW-1:0] r_div;
    logic          r_auto;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_scl;
    logic          r_sda_lo;

    logic          w_tick;
    logic [15:0]   w_word;
    logic [7:0]    w_next_byte;

    function automatic logic [15:0] f_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    f_rom = 16'h1E00;
            4'd1:    f_rom = 16'h0017;
            4'd2:    f_rom = 16'h0217;
            4'd3:    f_rom = 16'h0479;
            4'd4:    f_rom = 16'h0679;
            4'd5:    f_rom = 16'h0812;
            4'd6:    f_rom = 16'h0A00;
            4'd7:    f_rom = 16'h0C00;
            4'd8:    f_rom = 16'h0E42;
            4'd9:    f_rom = 16'h1000;
            4'd10:   f_rom = 16'h1201;
            default: f_rom = 16'h0000;
        endcase
    endfunction

    // Bus levels {scl, sda_lo} for a state/quarter; b is the data bit for BIT quarters.
    function automatic logic [1:0] f_bus(input state_t s, input logic [1:0] q, input logic b);
        case (s)
            S_START: f_bus = {q != 2'd3, q != 2'd0};
            S_BIT:   f_bus = {(q == 2'd1) || (q == 2'd2), ~b};
            S_ACK:   f_bus = {(q == 2'd1) || (q == 2'd2), 1'b0};
            S_STOP:  f_bus = {q != 2'd0, q < 2'd2};
            default: f_bus = 2'b10;
        endcase
    endfunction

    assign w_tick      = (r_div == DW'(CLK_DIV - 1));
    assign w_word      = f_rom(r_idx);
    assign w_next_byte = (r_byte == 2'd0) ? w_word[15:8] : w_word[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_q      <= 2'd0;
            r_bit    <= 3'd0;
            r_byte   <= 2'd0;
            r_sh     <= 8'd0;
            r_idx    <= 4'd0;
            r_div    <= '0;
            r_auto   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_scl    <= 1'b1;
            r_sda_lo <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            case (r_state)
                S_IDLE: if (r_auto || start) begin
                    r_state <= S_START;
                    r_q     <= 2'd0;
                    r_idx   <= 4'd0;
                    r_div   <= '0;
                    r_auto  <= 1'b0;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    {r_scl, r_sda_lo} <= f_bus(S_START, 2'd0, 1'b0);
                end
                S_FIN: r_state <= S_IDLE;
                default: if (w_tick) begin
                    if (r_q != 2'd3) begin
                        r_q <= r_q + 2'd1;
                        {r_scl, r_sda_lo} <= f_bus(r_state, r_q + 2'd1, r_sh[7]);
`ifdef I2C_ACK_CHECK_EN
                        if (r_state == S_ACK && r_q == 2'd2 && I2C_SDAT)
                            r_err <= 1'b1;
`endif
                    end else begin
                        r_q <= 2'd0;
                        case (r_state)
                            S_START: begin
                                r_state <= S_BIT;
                                r_byte  <= 2'd0;
                                r_bit   <= 3'd0;
                                r_sh    <= DEV_ADDR;
                                {r_scl, r_sda_lo} <= f_bus(S_BIT, 2'd0, DEV_ADDR[7]);
                            end
                            S_BIT: if (r_bit == 3'd7) begin
                                r_state <= S_ACK;
                                {r_scl, r_sda_lo} <= f_bus(S_ACK, 2'd0, 1'b0);
                            end else begin
                                r_bit <= r_bit + 3'd1;
                                r_sh  <= {r_sh[6:0], 1'b0};
                                {r_scl, r_sda_lo} <= f_bus(S_BIT, 2'd0, r_sh[6]);
                            end
                            // A NACK (r_err) cuts the frame short straight into STOP.
                            S_ACK: if (r_byte == 2'd2 || r_err) begin
                                r_state <= S_STOP;
                                {r_scl, r_sda_lo} <= f_bus(S_STOP, 2'd0, 1'b0);
                            end else begin
                                r_state <= S_BIT;
                                r_byte  <= r_byte + 2'd1;
                                r_bit   <= 3'd0;
                                r_sh    <= w_next_byte;
                                {r_scl, r_sda_lo} <= f_bus(S_BIT, 2'd0, w_next_byte[7]);
                            end
                            S_STOP: begin
                                r_state <= S_GAP;
                                {r_scl, r_sda_lo} <= f_bus(S_GAP, 2'd0, 1'b0);
                            end
                            default: if (r_idx == 4'd10 || r_err) begin
                                r_state <= S_FIN;
                                r_busy  <= 1'b0;
                                r_done  <= ~r_err;
                            end else begin
                                r_state <= S_START;
                                r_idx   <= r_idx + 4'd1;
                                {r_scl, r_sda_lo} <= f_bus(S_START, 2'd0, 1'b0);
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign I2C_SCLK = r_scl;
    assign I2C_SDAT = r_sda_lo ? 1'b0 : 1'bz;
    assign busy     = r_busy;
    assign done     = r_done;
    assign ack_err  = r_err;
    assign cur_idx  = r_idx;
endmodule

// File: tb/tb_i2c_codec_cfg.sv
// Bench for i2c_codec_cfg: I2C bus monitor + ACKing slave, scoreboard of decoded frames and run results.
`timescale 1ns/1ps
module tb_i2c_codec_cfg;
    localparam int CDIV    = 5;            // quarters scaled down; all timings are multiples of CDIV
    localparam int FRAME_Q = 120;
    localparam int RUN_LIM = 12 * FRAME_Q * CDIV + 200;
`ifdef I2C_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic       scl, busy, done, ack_err;
    logic [3:0] cur_idx;
    logic       slave_lo = 1'b0;
    wire        sda;

    pullup (sda);
    assign sda = slave_lo ? 1'b0 : 1'bz;

    i2c_codec_cfg #(.CLK_DIV(CDIV), .DEV_ADDR(8'h34)) dut (
        .clk(clk), .reset(reset), .start(start), .I2C_SCLK(scl), .I2C_SDAT(sda),
        .busy(busy), .done(done), .ack_err(ack_err), .cur_idx(cur_idx)
    );

    always #10 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int len; bit dn; bit err; int idx;} run_t;
    logic [31:0] exp_f[$];
    run_t        exp_r[$];
    logic [15:0] rom [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                              16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201};
    int total = 0, bad = 0;
    int nack_frame = -1, nack_byte = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Reference model: frames are {stop_ok=1, nbytes, addr, hi, lo}; a NACK truncates a frame and ends the table.
    task automatic plan_run(input int nf, input int nb);
        int q = 0;
        int last = 10;
        bit ab;
        logic [31:0] f;
        run_t r0;
        for (int i = 0; i < 11; i++) begin
            ab = ACK_CHK && (i == nf);
            f = {4'd1, ab ? 4'(nb + 1) : 4'd3, 8'h34,
                 (ab && nb < 1) ? 8'h00 : rom[i][15:8],
                 (ab && nb < 2) ? 8'h00 : rom[i][7:0]};
            exp_f.push_back(f);
            q += ab ? (4 + 36 * (nb + 1) + 8) : FRAME_Q;
            if (ab) begin
                last = i;
                break;
            end
        end
        r0.len = q * CDIV;
        r0.dn  = !(ACK_CHK && nf >= 0);
        r0.err = ACK_CHK && nf >= 0;
        r0.idx = last;
        exp_r.push_back(r0);
    endtask

    // Monitor: decodes the bus, plays the slave, and checks run boundaries.
    logic       p_scl = 1'b1, p_sda = 1'b1, p_busy = 1'b0;
    int         nbit = 0, nbytes = 0, frame_no = 0, t_busy = 0, runs_done = 0;
    bit         in_fr = 1'b0, fall_seen = 1'b1;
    logic [7:0] sh = 8'd0;
    logic [7:0] by [3];
    run_t       r;

    always @(negedge clk) begin
        if (reset) begin
            p_scl = 1'b1; p_sda = 1'b1; p_busy = 1'b0;
            nbit = 0; nbytes = 0; in_fr = 1'b0; slave_lo = 1'b0; fall_seen = 1'b1;
        end else begin
            if (busy && !p_busy) begin
                t_busy = cyc; fall_seen = 1'b0; frame_no = 0;
            end
            if (busy && !fall_seen && p_scl && !scl) begin
                fall_seen = 1'b1;
                chk("first_scl_fall", cyc - t_busy, 3 * CDIV);
            end
            if (!busy && p_busy) begin
                if (exp_r.size() == 0) fail_now("unexpected_run_end");
                else begin
                    r = exp_r.pop_front();
                    chk("run_len", cyc - t_busy, r.len);
                    chk("run_done", int'(done), int'(r.dn));
                    chk("run_ack_err", int'(ack_err), int'(r.err));
                    chk("run_cur_idx", int'(cur_idx), r.idx);
                end
                runs_done++;
            end
            if (p_scl && scl && p_sda && !sda) begin
                if (in_fr) fail_now("start_inside_frame");
                in_fr = 1'b1; nbit = 0; nbytes = 0; by = '{default: 8'h00};
            end else if (p_scl && scl && !p_sda && sda && in_fr) begin
                if (exp_f.size() == 0) fail_now("unexpected_frame");
                else chk($sformatf("frame%0d", frame_no),
                         {4'(nbit), 4'(nbytes), by[0], by[1], by[2]}, exp_f.pop_front());
                in_fr = 1'b0;
                frame_no++;
            end
            if (!p_scl && scl && in_fr) begin
                if (nbit < 8) sh = {sh[6:0], sda};
                nbit++;
            end
            if (p_scl && !scl && in_fr) begin
                if (nbit == 8) begin
                    if (!(frame_no == nack_frame && nbytes == nack_byte)) slave_lo = 1'b1;
                end else if (nbit == 9) begin
                    slave_lo = 1'b0;
                    if (nbytes < 3) by[nbytes] = sh;
                    nbytes++;
                    nbit = 0;
                end
            end
            p_scl = scl; p_sda = sda; p_busy = busy;
        end
    end

    task automatic wait_end();
        int c0 = runs_done;
        for (int i = 0; i < RUN_LIM; i++) begin
            @(negedge clk);
            if (runs_done != c0) return;
        end
        fail_now("run_timeout");
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int  w, tf, tb;
        bit  hit;
        repeat (3) @(negedge clk);
        chk("rst_scl", int'(scl), 1);
        chk("rst_sda", int'(sda), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ack_err", int'(ack_err), 0);
        chk("rst_cur_idx", int'(cur_idx), 0);

        // auto-start after release, with an ignored start pulse mid-run
        plan_run(-1, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("busy_after_release", int'(busy), 1);
        w = $urandom_range(20, 11 * FRAME_Q * CDIV - 200);
        repeat (w) @(negedge clk);
        pulse_start();
        wait_end();

        // restart after done
        w = $urandom_range(1, 40);
        repeat (w) @(negedge clk);
        chk("done_level", int'(done), 1);
        plan_run(-1, 0);
        pulse_start();
        chk("done_cleared", int'(done), 0);
        chk("busy_restart", int'(busy), 1);
        wait_end();

        // slave NACKs one random slot
        nack_frame = $urandom_range(0, 10);
        nack_byte  = $urandom_range(0, 2);
        plan_run(nack_frame, nack_byte);
        pulse_start();
        wait_end();
        nack_frame = -1;
        chk("nack_err_level", int'(ack_err), int'(ACK_CHK));
        chk("nack_done_level", int'(done), int'(!ACK_CHK));

        // reset in the middle of a data bit
        plan_run(-1, 0);
        pulse_start();
        tf = $urandom_range(1, 9);
        tb = $urandom_range(1, 6);
        hit = 1'b0;
        for (int i = 0; i < RUN_LIM && !hit; i++) begin
            @(negedge clk);
            if (int'(cur_idx) == tf && nbit == tb && in_fr) hit = 1'b1;
        end
        if (!hit) fail_now("reset_target_timeout");
        #1 reset = 1'b1;
        #1;
        chk("midrst_scl", int'(scl), 1);
        chk("midrst_sda", int'(sda), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_cur_idx", int'(cur_idx), 0);
        exp_f.delete();
        exp_r.delete();
        repeat (3) @(negedge clk);
        plan_run(-1, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("busy_after_rerelease", int'(busy), 1);
        wait_end();
        chk("frames_left", exp_f.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
